// File: rtl/gemm_seq_pkg.sv
// Shared types for the GEMM issue sequencer: queued request,
// delay-line writeback tag and FSM state.
package gemm_seq_pkg;

    localparam int GS_DIM   = 4;
    localparam int GS_REG_W = 4;
    localparam int GS_ROW_W = $clog2(GS_DIM);

    typedef struct packed {
        logic                new_weight;
        logic [GS_REG_W-1:0] rs1;
        logic [GS_REG_W-1:0] rs2;
        logic [GS_REG_W-1:0] rs3;
        logic [GS_REG_W-1:0] rd;
    } gemm_req_t;

    typedef struct packed {
        logic                valid;
        logic [GS_REG_W-1:0] rd;
        logic [GS_ROW_W-1:0] row;
    } wb_tag_t;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_WLOAD = 2'd1,
        GS_FEED  = 2'd2
    } gemm_seq_state_t;

endpackage

// File: rtl/gemm_req_fifo.sv
// Small request queue between fu_gemm and the sequencer FSM.
// Pushes while full are ignored; upstream holds the request.
module gemm_req_fifo
    import gemm_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  gemm_req_t din,
    input  logic      pop,
    output gemm_req_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    gemm_req_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= nxt(wptr);
            end
            if (do_pop) begin
                rptr <= nxt(rptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_sequencer.sv
// Sequences GEMM ops into row reads, systolic-array strobes and
// delayed writeback tags, with RAW and weight-reload drain interlocks.
module gemm_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int DIM        = GS_DIM,
    parameter int REG_W      = GS_REG_W,
    parameter int FIFO_DEPTH = 2,
    parameter int ARRAY_LAT  = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   gemm_enable,
    input  logic                   new_weight_in,
    input  logic [REG_W-1:0]       rs1_in,
    input  logic [REG_W-1:0]       rs2_in,
    input  logic [REG_W-1:0]       rs3_in,
    input  logic [REG_W-1:0]       rd_in,
    output logic                   gemm_ready,
    output logic                   rf_ren,
    output logic [REG_W-1:0]       rf_raddr_a,
    output logic [REG_W-1:0]       rf_raddr_b,
    output logic [$clog2(DIM)-1:0] rf_row,
    input  logic                   rf_ready,
    output logic                   sa_weight_load,
    output logic                   sa_input_push,
    output logic                   wb_valid,
    output logic [REG_W-1:0]       wb_rd,
    output logic [$clog2(DIM)-1:0] wb_row,
    output logic                   busy
);

    localparam int            RW   = $clog2(DIM);
    localparam logic [RW-1:0] LAST = RW'(DIM - 1);

    gemm_req_t       req_in;
    gemm_req_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    gemm_seq_state_t state;
    logic [RW-1:0]   row;
    logic            weights_valid;
    logic [REG_W-1:0] cur_rs1;
    logic [REG_W-1:0] cur_rs2;
    logic [REG_W-1:0] cur_rs3;
    logic [REG_W-1:0] cur_rd;
    wb_tag_t         dl [ARRAY_LAT];
    logic            hazard;
    logic            dl_empty;
    logic            need_wload;
    logic            push_row;

    assign req_in = gemm_req_t'{
        new_weight: new_weight_in,
        rs1: rs1_in, rs2: rs2_in,
        rs3: rs3_in, rd: rd_in
    };

    gemm_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (gemm_enable),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Every valid delay-line stage is a row still owed to its rd.
    always_comb begin
        hazard   = 1'b0;
        dl_empty = 1'b1;
        for (int i = 0; i < ARRAY_LAT; i++) begin
            if (dl[i].valid) begin
                dl_empty = 1'b0;
                if (dl[i].rd == head.rs1 ||
                    dl[i].rd == head.rs2 ||
                    dl[i].rd == head.rs3) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign need_wload = head.new_weight || !weights_valid;
    assign pop = (state == GS_IDLE) && !fifo_empty && !hazard
              && (dl_empty || !need_wload);
    assign push_row = (state == GS_FEED) && rf_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= GS_IDLE;
            row           <= '0;
            weights_valid <= 1'b0;
            cur_rs1       <= '0;
            cur_rs2       <= '0;
            cur_rs3       <= '0;
            cur_rd        <= '0;
        end else begin
            unique case (state)
                GS_IDLE: begin
                    if (pop) begin
                        cur_rs1 <= head.rs1;
                        cur_rs2 <= head.rs2;
                        cur_rs3 <= head.rs3;
                        cur_rd  <= head.rd;
                        row     <= '0;
                        state   <= need_wload ? GS_WLOAD : GS_FEED;
                    end
                end
                GS_WLOAD: begin
                    if (rf_ready) begin
                        if (row == LAST) begin
                            row           <= '0;
                            weights_valid <= 1'b1;
                            state         <= GS_FEED;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                GS_FEED: begin
                    if (rf_ready) begin
                        if (row == LAST) begin
                            row   <= '0;
                            state <= GS_IDLE;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                default: state <= GS_IDLE;
            endcase
        end
    end

    // Free-running: the array drains at a fixed rate whatever the RF does.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ARRAY_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= push_row
                   ? wb_tag_t'{valid: 1'b1, rd: cur_rd, row: row}
                   : wb_tag_t'('0);
            for (int i = 1; i < ARRAY_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign gemm_ready     = !fifo_full;
    assign rf_ren         = (state != GS_IDLE);
    assign rf_raddr_a     = (state == GS_WLOAD) ? cur_rs2 :
                            (state == GS_FEED)  ? cur_rs1 : '0;
    assign rf_raddr_b     = (state == GS_FEED) ? cur_rs3 : '0;
    assign rf_row         = rf_ren ? row : '0;
    assign sa_weight_load = (state == GS_WLOAD) && rf_ready;
    assign sa_input_push  = push_row;
    assign wb_valid       = dl[ARRAY_LAT-1].valid;
    assign wb_rd          = dl[ARRAY_LAT-1].rd;
    assign wb_row         = dl[ARRAY_LAT-1].row;
    assign busy           = !fifo_empty || rf_ren || !dl_empty;

endmodule

// File: tb/tb_gemm_sequencer.sv
// Bench for gemm_sequencer: op-level queue/schedule model checked every
// cycle, plus directed literal timing checks.
module tb_gemm_sequencer;

    localparam int DIM = 4;
    localparam int LAT = 8;
    localparam int QD  = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       gemm_enable = 1'b0;
    logic       new_weight_in = 1'b0;
    logic [3:0] rs1_in = '0;
    logic [3:0] rs2_in = '0;
    logic [3:0] rs3_in = '0;
    logic [3:0] rd_in = '0;
    logic       rf_ready = 1'b1;
    logic       gemm_ready;
    logic       rf_ren;
    logic [3:0] rf_raddr_a;
    logic [3:0] rf_raddr_b;
    logic [1:0] rf_row;
    logic       sa_weight_load;
    logic       sa_input_push;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic [1:0] wb_row;
    logic       busy;

    gemm_sequencer #(
        .DIM(DIM), .REG_W(4), .FIFO_DEPTH(QD), .ARRAY_LAT(LAT)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .gemm_enable(gemm_enable), .new_weight_in(new_weight_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rs3_in(rs3_in), .rd_in(rd_in),
        .gemm_ready(gemm_ready), .rf_ren(rf_ren),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_row(rf_row), .rf_ready(rf_ready),
        .sa_weight_load(sa_weight_load),
        .sa_input_push(sa_input_push),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_row(wb_row), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int base = 0;

    typedef struct {
        bit nw;
        int rs1;
        int rs2;
        int rs3;
        int rd;
    } mreq_t;

    // mode: 0 no op, 1 loading weights, 2 feeding inputs
    mreq_t mq[$];
    mreq_t cur;
    int    mode = 0;
    int    rows = 0;
    bit    wv = 0;
    int    wbrd[int];
    int    wbrow[int];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     name, cyc - base, act, exp);
        end
    endtask

    task automatic model_step(input int c);
        int s0 = mq.size();
        int m0 = mode;
        bit owed = 0;
        bit haz = 0;
        foreach (wbrd[k]) begin
            if (k >= c) begin
                owed = 1;
                if (s0 > 0 && (wbrd[k] == mq[0].rs1 ||
                               wbrd[k] == mq[0].rs2 ||
                               wbrd[k] == mq[0].rs3)) haz = 1;
            end
        end
        if (m0 == 1 && rf_ready) begin
            rows++;
            if (rows == DIM) begin
                wv = 1;
                mode = 2;
                rows = 0;
            end
        end else if (m0 == 2 && rf_ready) begin
            wbrd[c + LAT] = cur.rd;
            wbrow[c + LAT] = rows;
            rows++;
            if (rows == DIM) begin
                mode = 0;
                rows = 0;
            end
        end else if (m0 == 0 && s0 > 0 && !haz) begin
            if (!(mq[0].nw || !wv) || !owed) begin
                mode = (mq[0].nw || !wv) ? 1 : 2;
                cur = mq.pop_front();
                rows = 0;
            end
        end
        if (gemm_enable && s0 < QD) begin
            mq.push_back(mreq_t'{new_weight_in, int'(rs1_in),
                                 int'(rs2_in), int'(rs3_in),
                                 int'(rd_in)});
        end
    endtask

    initial forever begin
        @(posedge CLK);
        if (!nRST) begin
            mq.delete();
            wbrd.delete();
            wbrow.delete();
            mode = 0;
            rows = 0;
            wv = 0;
        end else begin
            model_step(cyc);
        end
        cyc++;
    end

    initial forever begin
        int c;
        bit owed;
        @(negedge CLK);
        c = cyc;
        owed = 0;
        foreach (wbrd[k]) if (k >= c) owed = 1;
        if (!nRST) begin
            chk("m_ready", gemm_ready, 1);
            chk("m_busy", busy, 0);
            chk("m_ren", rf_ren, 0);
            chk("m_ra", rf_raddr_a, 0);
            chk("m_rb", rf_raddr_b, 0);
            chk("m_row", rf_row, 0);
            chk("m_wl", sa_weight_load, 0);
            chk("m_push", sa_input_push, 0);
            chk("m_wbv", wb_valid, 0);
            chk("m_wbrd", wb_rd, 0);
            chk("m_wbrow", wb_row, 0);
        end else begin
            chk("m_ready", gemm_ready, mq.size() < QD);
            chk("m_busy", busy, mq.size() > 0 || mode != 0 || owed);
            chk("m_ren", rf_ren, mode != 0);
            chk("m_ra", rf_raddr_a,
                mode == 1 ? cur.rs2 : mode == 2 ? cur.rs1 : 0);
            chk("m_rb", rf_raddr_b, mode == 2 ? cur.rs3 : 0);
            chk("m_row", rf_row, mode != 0 ? rows : 0);
            chk("m_wl", sa_weight_load, mode == 1 && rf_ready);
            chk("m_push", sa_input_push, mode == 2 && rf_ready);
            chk("m_wbv", wb_valid, wbrd.exists(c));
            chk("m_wbrd", wb_rd, wbrd.exists(c) ? wbrd[c] : 0);
            chk("m_wbrow", wb_row, wbrow.exists(c) ? wbrow[c] : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic at(input int t);
        while (cyc < base + t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic mid(input int t);
        at(t);
        @(negedge CLK);
    endtask

    task automatic start();
        @(posedge CLK);
        #1;
        base = cyc;
    endtask

    task automatic req(input bit nw, input int a, input int b,
                       input int c, input int d);
        gemm_enable = 1'b1;
        new_weight_in = nw;
        rs1_in = 4'(a);
        rs2_in = 4'(b);
        rs3_in = 4'(c);
        rd_in = 4'(d);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        gemm_enable = 1'b0;
        rf_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        // reset values
        @(negedge CLK);
        chk("rst_ready", gemm_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wbv", wb_valid, 0);
        do_reset();

        // single op, forced weight load
        start();
        req(0, 1, 2, 3, 4);
        at(1); gemm_enable = 1'b0;
        mid(1);  chk("s1_busy", busy, 1); chk("s1_ren1", rf_ren, 0);
        mid(2);  chk("s1_wl", sa_weight_load, 1);
                 chk("s1_wa", rf_raddr_a, 2); chk("s1_wr0", rf_row, 0);
        mid(5);  chk("s1_wr3", rf_row, 3);
        mid(6);  chk("s1_push", sa_input_push, 1);
                 chk("s1_fa", rf_raddr_a, 1); chk("s1_fb", rf_raddr_b, 3);
        mid(9);  chk("s1_fr3", rf_row, 3);
        mid(13); chk("s1_wb13", wb_valid, 0);
        mid(14); chk("s1_wbv", wb_valid, 1);
                 chk("s1_wbrd", wb_rd, 4); chk("s1_wbr0", wb_row, 0);
        mid(17); chk("s1_wbr3", wb_row, 3);
        mid(18); chk("s1_busy18", busy, 0); chk("s1_wb18", wb_valid, 0);

        // back-to-back, second op reuses weights
        do_reset();
        start();
        req(0, 1, 2, 3, 4);
        at(1); req(0, 2, 2, 3, 5);
        at(2); gemm_enable = 1'b0;
        mid(10); chk("s2_bubble", rf_ren, 0);
        mid(11); chk("s2_push", sa_input_push, 1);
                 chk("s2_fa", rf_raddr_a, 2); chk("s2_fb", rf_raddr_b, 3);
        mid(18); chk("s2_gap", wb_valid, 0);
        mid(19); chk("s2_wbv", wb_valid, 1);
                 chk("s2_wbrd", wb_rd, 5); chk("s2_wbr0", wb_row, 0);
        mid(22); chk("s2_wbr3", wb_row, 3);
        mid(23); chk("s2_busy", busy, 0);

        // RAW on rd=4
        do_reset();
        start();
        req(0, 1, 2, 3, 4);
        at(1); req(0, 4, 2, 3, 6);
        at(2); gemm_enable = 1'b0;
        mid(17); chk("s3_hold17", rf_ren, 0);
        mid(18); chk("s3_hold18", rf_ren, 0);
        mid(19); chk("s3_push", sa_input_push, 1);
                 chk("s3_fa", rf_raddr_a, 4);
        mid(27); chk("s3_wbrd", wb_rd, 6); chk("s3_wbv", wb_valid, 1);

        // weight reload waits for full drain
        do_reset();
        start();
        req(0, 1, 2, 3, 4);
        at(1); req(1, 7, 8, 9, 6);
        at(2); gemm_enable = 1'b0;
        mid(12); chk("s4_hold12", rf_ren, 0);
        mid(18); chk("s4_hold18", rf_ren, 0);
        mid(19); chk("s4_wl", sa_weight_load, 1);
                 chk("s4_wa", rf_raddr_a, 8);
        mid(23); chk("s4_fa", rf_raddr_a, 7); chk("s4_fb", rf_raddr_b, 9);
        mid(31); chk("s4_wbv", wb_valid, 1); chk("s4_wbrd", wb_rd, 6);

        // rf stall during feed
        do_reset();
        start();
        req(0, 1, 2, 3, 4);
        at(1); gemm_enable = 1'b0;
        at(7); rf_ready = 1'b0;
        mid(7);  chk("s5_push7", sa_input_push, 0);
                 chk("s5_row7", rf_row, 1); chk("s5_fa7", rf_raddr_a, 1);
        mid(9);  chk("s5_row9", rf_row, 1);
        at(10); rf_ready = 1'b1;
        mid(10); chk("s5_push10", sa_input_push, 1);
                 chk("s5_row10", rf_row, 1);
        mid(12); chk("s5_row12", rf_row, 3);
        mid(14); chk("s5_wb14", wb_row, 0);
        mid(17); chk("s5_gap", wb_valid, 0);
        mid(18); chk("s5_wb18", wb_row, 1); chk("s5_wbv18", wb_valid, 1);
        mid(20); chk("s5_wb20", wb_row, 3);

        // queue full, then reset mid-operation
        do_reset();
        start();
        req(0, 1, 2, 3, 4);
        at(1); gemm_enable = 1'b0;
        at(3); req(0, 10, 11, 12, 9);
        mid(3); chk("s6_rdy3", gemm_ready, 1);
        at(4); req(0, 10, 11, 12, 13);
        mid(4); chk("s6_rdy4", gemm_ready, 1);
        at(5); req(0, 10, 11, 12, 14);
        mid(5); chk("s6_full", gemm_ready, 0); chk("s6_busy", busy, 1);
        at(6); gemm_enable = 1'b0;
        mid(6); chk("s6_full6", gemm_ready, 0);
        at(8); nRST = 1'b0;
        mid(8); chk("s6_rrdy", gemm_ready, 1); chk("s6_rbusy", busy, 0);
                chk("s6_rren", rf_ren, 0); chk("s6_rpush", sa_input_push, 0);
        at(10); nRST = 1'b1;
        for (int t = 11; t < 40; t++) begin
            mid(t);
            chk("s6_nowb", wb_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gemm_sequencer.md
Name: gemm_sequencer

Overview:
Sits directly downstream of fu_gemm. It accepts GEMM issue requests (rs1 = input matrix reg, rs2 = weight matrix reg, rs3 = partial-sum matrix reg, rd = destination reg), queues them, and sequences row reads from the matrix register file. It also drives weight-load and input-push strobes into the weight-stationary systolic array and emits per-row writeback tags to rd after the fixed array latency. It enforces RAW hazards on in-flight destinations and the weight-reload drain rule.

Parameters:
DIM, 4, array dimension; rows per matrix register
REG_W, 4, matrix register index width
FIFO_DEPTH, 2, request queue entries
ARRAY_LAT, 8, cycles from input-row push to matching output row

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
gemm_enable  in  1  request valid from fu_gemm
new_weight_in  in  1  reload weights from rs2 before feeding
rs1_in  in  REG_W  input matrix reg
rs2_in  in  REG_W  weight matrix reg
rs3_in  in  REG_W  partial-sum matrix reg
rd_in  in  REG_W  destination matrix reg
gemm_ready  out  1  queue not full; request accepted when gemm_enable & gemm_ready
rf_ren  out  1  register-file read request
rf_raddr_a  out  REG_W  port A reg (rs2 in WLOAD, rs1 in FEED)
rf_raddr_b  out  REG_W  port B reg (rs3 in FEED)
rf_row  out  $clog2(DIM)  row index for both ports
rf_ready  in  1  read accepted this cycle; 0 = stall
sa_weight_load  out  1  array latches weight row rf_row
sa_input_push  out  1  array accepts input/psum row rf_row
wb_valid  out  1  array output row valid, write to wb_rd
wb_rd  out  REG_W  writeback destination
wb_row  out  $clog2(DIM)  writeback row
busy  out  1  queue non-empty, FSM not IDLE, or any delay-line entry valid

Behaviour:
- Reset: all outputs 0 except gemm_ready=1; queue emptied, delay line cleared, weights_valid=0, FSM in IDLE. Asserting reset mid-operation discards all queued and in-flight work with no writebacks.
- Queue: FIFO of {new_weight, rs1, rs2, rs3, rd}. gemm_ready = !full. A push when full is not accepted and upstream holds the request. Push and pop in the same cycle are legal when not full.
- FSM states: IDLE, WLOAD, FEED.
- IDLE → pop head when all of the following hold:
  - the queue is non-empty;
  - none of the head's rs1/rs2/rs3 equals the rd of any valid delay-line entry (RAW);
  - if the load is a weight load (head.new_weight, or weights_valid=0), the delay line is fully empty.
  Next state is WLOAD for a weight load, else FEED. The popped entry is latched into current-op registers and the row counter is set to 0.
- WLOAD: rf_ren=1, rf_raddr_a=rs2. sa_weight_load = rf_ready. On rf_ready the row counter increments. On row DIM-1 accepted: weights_valid=1 and go to FEED with row=0.
- FEED: rf_ren=1, rf_raddr_a=rs1, rf_raddr_b=rs3. sa_input_push = rf_ready. On rf_ready, {1, rd, row} enters the delay line and the row increments. On row DIM-1 accepted, go to IDLE. There is a one-cycle IDLE bubble between ops.
- rf_ready=0: addresses and row are held, strobes are low, and the counter does not advance.
- Delay line: ARRAY_LAT-stage shift register, free-running regardless of stalls. The output stage drives wb_valid, wb_rd and wb_row, so a row pushed in cycle t appears at wb in cycle t+ARRAY_LAT.
- Row counter wraps only through the state transition; it never exceeds DIM-1.
- Outputs rf_raddr_b and rf_raddr_a read 0 when rf_ren=0.

Decomposition:
- Shared package gemm_seq_pkg:
  - gemm_req_t struct {new_weight, rs1, rs2, rs3, rd};
  - wb_tag_t {valid, rd, row};
  - state enum gemm_seq_state_t.
- One natural sub-module: gemm_req_fifo (parameterised FIFO of gemm_req_t). The delay line stays inline.

Test Plan:
1. Reset with DIM=4, ARRAY_LAT=8 → gemm_ready=1, busy=0, all other outputs 0.
2. First op, cycle 0: enable, new_weight=0, rs1=1, rs2=2, rs3=3, rd=4, rf_ready=1 → popped in cycle 1 (forced WLOAD, weights_valid=0).
   - WLOAD cycles 2–5: raddr_a=2, rows 0–3.
   - FEED cycles 6–9: raddr_a=1, raddr_b=3.
   - wb_valid cycles 14–17: rd=4, rows 0–3.
   - busy=0 in cycle 18.
3. Back-to-back second op (new_weight=0, rs1=2, rs3=3, rd=5) queued behind op 2 → no WLOAD; FEED starts cycle 11; wb rows for rd=5 appear in cycles 19–22.
4. RAW and drain cases:
   - Op A with rd=4 followed by op B with rs1=4 → B pops only after A's row-3 wb (cycle 17); B FEED begins cycle 19.
   - Repeating the scenario with B.new_weight=1 → identical timing via the drain rule.
5. rf_ready=0 for cycles 7–9 during FEED → strobes low and row held at 1. Rows 1–3 push in cycles 10–12, and wb gaps shift by 3 cycles.
6. Full and reset cases:
   - Three enables on consecutive cycles while busy → third sees gemm_ready=0 and is not accepted.
   - Dropping nRST in cycle 8 → all outputs 0 next edge, no wb_valid afterwards, gemm_ready=1.
